// File: rtl/player_pkg.sv
// ============================================================================
//  Module      : player_pkg
//  Description : Shared constants for the player motion controller: default
//                screen/sprite geometry, axis FSM state encodings, button
//                request bit positions and at_edge bit indices.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package player_pkg;

    // Default geometry (640x480 active area, 32x16 sprite)
    localparam int c_screen_w = 640;
    localparam int c_screen_h = 480;
    localparam int c_player_w = 32;
    localparam int c_player_h = 16;
    localparam int c_step     = 4;
    localparam int c_pos_w    = 10;

    // Axis FSM state encoding
    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_hold   = 2'd1;
    localparam logic [1:0] c_st_repeat = 2'd2;

    // Bit positions of the synchronised, active-high button requests
    localparam int c_btn_left  = 0;
    localparam int c_btn_right = 1;
    localparam int c_btn_up    = 2;
    localparam int c_btn_down  = 3;

    // at_edge bit indices: {top, bottom, right, left}
    localparam int c_edge_left   = 0;
    localparam int c_edge_right  = 1;
    localparam int c_edge_bottom = 2;
    localparam int c_edge_top    = 3;

endpackage

`default_nettype wire

// File: rtl/player_motion_axis.sv
// ============================================================================
//  Module      : axis_motion
//  Description : One axis of player motion. Press-to-move FSM
//                (IDLE/HOLD/REPEAT) with a hold delay before auto-repeat and
//                a saturating clamp to [0, LIMIT].
//                Optional macro PLAYER_ACCEL_EN: in REPEAT the step doubles
//                after every 8 repeat moves, capped at 4*STEP.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

import player_pkg::*;

module axis_motion #(
    parameter int POS_W         = 10,
    parameter int LIMIT         = 608,
    parameter int START         = 304,
    parameter int STEP          = 4,
    parameter int HOLD_DELAY    = 12_500_000,
    parameter int REPEAT_PERIOD = 1_250_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    input  logic             i_neg,
    input  logic             i_pos,
    output logic [POS_W-1:0] o_pos,
    output logic             o_moved
);

    localparam int c_cnt_max = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
    localparam int c_cnt_w   = (c_cnt_max > 2) ? $clog2(c_cnt_max) : 1;

    localparam logic [POS_W:0]     c_limit     = (POS_W+1)'(LIMIT);
    localparam logic [POS_W:0]     c_step_base = (POS_W+1)'(STEP);
    localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(HOLD_DELAY - 1);
    localparam logic [c_cnt_w-1:0] c_rep_last  = c_cnt_w'(REPEAT_PERIOD - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               r_dir;        // 1 = positive direction latched at press
    logic               w_dir_nxt;
    logic               w_move;
    logic               w_move_dir;
    logic               w_held;
    logic [POS_W:0]     w_step;
    logic [POS_W:0]     w_pos_ext;
    logic [POS_W:0]     w_sum;
    logic [POS_W:0]     w_dec;
    logic [POS_W:0]     w_inc;
    logic [POS_W-1:0]   w_pos_nxt;
    logic [POS_W-1:0]   r_pos;
    logic               r_moved;

    // Held means the originally pressed direction is still the only request;
    // a direction swap therefore drops to IDLE before the new press registers.
    assign w_held = r_dir ? (i_pos & ~i_neg) : (i_neg & ~i_pos);

`ifdef PLAYER_ACCEL_EN
    logic [2:0] r_rep_moves;
    logic [1:0] r_shift;

    assign w_step = c_step_base << r_shift;

    // Count repeat moves; every 8th doubles the step until it reaches 4*STEP
    always_ff @(posedge clk) begin
        if (rst || r_state != c_st_repeat || w_state_nxt != c_st_repeat) begin
            r_rep_moves <= 3'd0;
            r_shift     <= 2'd0;
        end else if (w_move) begin
            r_rep_moves <= r_rep_moves + 3'd1;
            if (r_rep_moves == 3'd7 && r_shift != 2'd2) begin
                r_shift <= r_shift + 2'd1;
            end
        end
    end
`else
    assign w_step = c_step_base;
`endif

    // Saturating clamp, computed one bit wider than the position
    assign w_pos_ext = {1'b0, r_pos};
    assign w_sum     = w_pos_ext + w_step;
    assign w_dec     = (w_pos_ext < w_step) ? '0 : (w_pos_ext - w_step);
    assign w_inc     = (w_sum > c_limit) ? c_limit : w_sum;

    // Next-state, counter and move-request decode
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
        w_move      = 1'b0;
        w_move_dir  = r_dir;
        if (!i_enable) begin
            w_state_nxt = c_st_idle;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    w_cnt_nxt = '0;
                    if (i_neg ^ i_pos) begin
                        w_move      = 1'b1;
                        w_move_dir  = i_pos;
                        w_dir_nxt   = i_pos;
                        w_state_nxt = c_st_hold;
                    end
                end
                c_st_hold: begin
                    if (!w_held) begin
                        w_state_nxt = c_st_idle;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_hold_last) begin
                        w_move      = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = c_st_repeat;
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_w'(1);
                    end
                end
                c_st_repeat: begin
                    if (!w_held) begin
                        w_state_nxt = c_st_idle;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_rep_last) begin
                        w_move    = 1'b1;
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_w'(1);
                    end
                end
                default: begin
                    w_state_nxt = c_st_idle;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign w_pos_nxt = w_move ? (w_move_dir ? w_inc[POS_W-1:0] : w_dec[POS_W-1:0]) : r_pos;

    // State, counter and position registers; moved flags a real position change
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_pos   <= POS_W'(START);
            r_moved <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
            r_pos   <= w_pos_nxt;
            r_moved <= (w_pos_nxt != r_pos);
        end
    end

    assign o_pos   = r_pos;
    assign o_moved = r_moved;

endmodule

`default_nettype wire

// File: rtl/player_motion_ctrl.sv
// ============================================================================
//  Module      : player_motion_ctrl
//  Description : Two-axis player position controller. Synchronises four
//                active-low buttons and drives one axis_motion per axis.
//                Optional macro PLAYER_ACCEL_EN enables repeat acceleration
//                inside axis_motion.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

import player_pkg::*;

module player_motion_ctrl #(
    parameter int SCREEN_W      = c_screen_w,
    parameter int SCREEN_H      = c_screen_h,
    parameter int PLAYER_W      = c_player_w,
    parameter int PLAYER_H      = c_player_h,
    parameter int START_X       = (SCREEN_W - PLAYER_W) / 2,
    parameter int START_Y       = SCREEN_H - 4 - PLAYER_H,
    parameter int STEP          = c_step,
    parameter int HOLD_DELAY    = 12_500_000,
    parameter int REPEAT_PERIOD = 1_250_000,
    parameter int SYNC_STAGES   = 2,
    parameter int POS_W         = c_pos_w
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             enable,
    input  logic             left_button,
    input  logic             right_button,
    input  logic             up_button,
    input  logic             down_button,
    output logic [POS_W-1:0] player_x,
    output logic [POS_W-1:0] player_y,
    output logic             moving,
    output logic [3:0]       at_edge
);

    localparam int c_x_limit = SCREEN_W - PLAYER_W;
    localparam int c_y_limit = SCREEN_H - PLAYER_H;

    logic [3:0] r_sync [SYNC_STAGES];
    logic [3:0] w_req;
    logic       w_x_moved;
    logic       w_y_moved;

    // Button synchroniser chain; released (1) out of reset
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= 4'hF;
            end
        end else begin
            r_sync[0] <= {down_button, up_button, right_button, left_button};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_req = ~r_sync[SYNC_STAGES-1];

    axis_motion #(
        .POS_W         (POS_W),
        .LIMIT         (c_x_limit),
        .START         (START_X),
        .STEP          (STEP),
        .HOLD_DELAY    (HOLD_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_axis_x (
        .clk      (CLOCK_50),
        .rst      (reset),
        .i_enable (enable),
        .i_neg    (w_req[c_btn_left]),
        .i_pos    (w_req[c_btn_right]),
        .o_pos    (player_x),
        .o_moved  (w_x_moved)
    );

    axis_motion #(
        .POS_W         (POS_W),
        .LIMIT         (c_y_limit),
        .START         (START_Y),
        .STEP          (STEP),
        .HOLD_DELAY    (HOLD_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_axis_y (
        .clk      (CLOCK_50),
        .rst      (reset),
        .i_enable (enable),
        .i_neg    (w_req[c_btn_up]),
        .i_pos    (w_req[c_btn_down]),
        .o_pos    (player_y),
        .o_moved  (w_y_moved)
    );

    assign moving = w_x_moved | w_y_moved;

    // Edge flags derived directly from the current position
    always_comb begin
        at_edge                = 4'b0000;
        at_edge[c_edge_left]   = (player_x == '0);
        at_edge[c_edge_right]  = (player_x == POS_W'(c_x_limit));
        at_edge[c_edge_top]    = (player_y == '0);
        at_edge[c_edge_bottom] = (player_y == POS_W'(c_y_limit));
    end

endmodule

`default_nettype wire

// File: tb/tb_player_motion_ctrl.sv
// ============================================================================
//  Module      : tb_player_motion_ctrl
//  Description : Directed, scoreboard-based bench for player_motion_ctrl with
//                short hold/repeat timing and a 642-pixel screen so that the
//                right limit (610) is not a multiple of the step.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_player_motion_ctrl;

    localparam int c_x_lim = 610;   // 642 - 32
    localparam int c_y_lim = 464;   // 480 - 16

    logic       CLOCK_50     = 1'b0;
    logic       reset        = 1'b1;
    logic       enable       = 1'b1;
    logic       left_button  = 1'b1;
    logic       right_button = 1'b1;
    logic       up_button    = 1'b1;
    logic       down_button  = 1'b1;
    logic [9:0] player_x;
    logic [9:0] player_y;
    logic       moving;
    logic [3:0] at_edge;

    int          checks = 0;
    int          errors = 0;
    int          mx;
    int          my;
    string       tag_q[$];
    logic [31:0] val_q[$];

    player_motion_ctrl #(
        .SCREEN_W      (642),
        .SCREEN_H      (480),
        .PLAYER_W      (32),
        .PLAYER_H      (16),
        .START_X       (304),
        .START_Y       (460),
        .STEP          (4),
        .HOLD_DELAY    (8),
        .REPEAT_PERIOD (4),
        .SYNC_STAGES   (2),
        .POS_W         (10)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .enable       (enable),
        .left_button  (left_button),
        .right_button (right_button),
        .up_button    (up_button),
        .down_button  (down_button),
        .player_x     (player_x),
        .player_y     (player_y),
        .moving       (moving),
        .at_edge      (at_edge)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic push(input string tag, input int v);
        tag_q.push_back(tag);
        val_q.push_back(32'(v));
    endtask

    task automatic check_next(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        checks++;
        if (val_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
        end else begin
            t = tag_q.pop_front();
            e = val_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%0d expected=%0d", t, obs, e);
            end
        end
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0:       left_button  = v;
            1:       right_button = v;
            2:       up_button    = v;
            default: down_button  = v;
        endcase
    endtask

    // Single press/release of one button; checks x, y and moving when it lands
    task automatic tap(input int b);
        int ox;
        int oy;
        ox = mx;
        oy = my;
        case (b)
            0:       mx = (mx < 4) ? 0 : mx - 4;
            1:       mx = (mx + 4 > c_x_lim) ? c_x_lim : mx + 4;
            2:       my = (my < 4) ? 0 : my - 4;
            default: my = (my + 4 > c_y_lim) ? c_y_lim : my + 4;
        endcase
        push("tap_x", mx);
        push("tap_y", my);
        push("tap_moving", (mx != ox || my != oy) ? 1 : 0);
        set_btn(b, 1'b0);
        tick(1);
        set_btn(b, 1'b1);
        tick(2);
        check_next(32'(player_x));
        check_next(32'(player_y));
        check_next(32'(moving));
        tick(2);
    endtask

    initial begin
        // Reset values
        tick(3);
        mx = 304;
        my = 460;
        push("reset_x", 304);
        push("reset_y", 460);
        push("reset_moving", 0);
        push("reset_at_edge", 0);
        check_next(32'(player_x));
        check_next(32'(player_y));
        check_next(32'(moving));
        check_next(32'(at_edge));
        reset = 1'b0;
        tick(2);

        // One-cycle left press: lands exactly 3 cycles after the pin edge
        push("lat_2cyc_x", 304);
        left_button = 1'b0;
        tick(1);
        left_button = 1'b1;
        tick(1);
        check_next(32'(player_x));
        push("lat_3cyc_x", 300);
        push("lat_3cyc_moving", 1);
        tick(1);
        check_next(32'(player_x));
        check_next(32'(moving));
        push("lat_after_x", 300);
        push("lat_after_moving", 0);
        tick(4);
        check_next(32'(player_x));
        check_next(32'(moving));
        mx = 300;

        // Right held: press, hold delay 8, then repeat every 4
        right_button = 1'b0;
        push("hold_press_x", 304);
        tick(3);
        check_next(32'(player_x));
        push("hold_wait_x", 304);
        tick(7);
        check_next(32'(player_x));
        push("hold_first_rep_x", 308);
        tick(1);
        check_next(32'(player_x));
        push("repeat1_x", 312);
        tick(4);
        check_next(32'(player_x));
        push("repeat2_x", 316);
        tick(4);
        check_next(32'(player_x));
        push("repeat3_x", 320);
        tick(4);
        check_next(32'(player_x));
        right_button = 1'b1;
        push("release_x", 320);
        push("release_moving", 0);
        tick(6);
        check_next(32'(player_x));
        check_next(32'(moving));
        mx = 320;

        // Up and down together: no motion; releasing down lets up act
        up_button   = 1'b0;
        down_button = 1'b0;
        push("both_y", 460);
        tick(50);
        check_next(32'(player_y));
        down_button = 1'b1;
        push("up_only_wait_y", 460);
        tick(2);
        check_next(32'(player_y));
        push("up_only_y", 456);
        push("up_only_moving", 1);
        tick(1);
        check_next(32'(player_y));
        check_next(32'(moving));
        up_button = 1'b1;
        push("up_release_y", 456);
        tick(6);
        check_next(32'(player_y));
        my = 456;

        // Disabled: frozen; re-enable with button held is a fresh press
        enable       = 1'b0;
        right_button = 1'b0;
        push("disabled_x", 320);
        tick(10);
        check_next(32'(player_x));
        enable = 1'b1;
        push("reenable_x", 324);
        tick(1);
        check_next(32'(player_x));
        right_button = 1'b1;
        tick(6);

        // Reset during REPEAT with the button still held
        right_button = 1'b0;
        push("pre_reset_press_x", 328);
        tick(3);
        check_next(32'(player_x));
        push("pre_reset_rep_x", 332);
        tick(8);
        check_next(32'(player_x));
        tick(2);
        reset = 1'b1;
        push("midrep_reset_x", 304);
        push("midrep_reset_y", 460);
        push("midrep_reset_moving", 0);
        tick(1);
        check_next(32'(player_x));
        check_next(32'(player_y));
        check_next(32'(moving));
        reset = 1'b0;
        push("post_reset_wait_x", 304);
        tick(2);
        check_next(32'(player_x));
        push("post_reset_press_x", 308);
        tick(1);
        check_next(32'(player_x));
        right_button = 1'b1;
        tick(6);
        mx = 308;
        my = 460;

        // Long right hold saturates at the right limit
        right_button = 1'b0;
        tick(400);
        right_button = 1'b1;
        tick(6);
        mx = c_x_lim;
        push("right_clamp_x", c_x_lim);
        push("right_clamp_edge", 4'b0010);
        check_next(32'(player_x));
        check_next(32'(at_edge));

        // Left taps from 610 down to 2, then 0, then a blocked attempt at 0
        for (int i = 0; i < 154; i++) begin
            tap(0);
        end
        push("left_clamp_edge", 4'b0001);
        check_next(32'(at_edge));

        // Down taps: 456 isn't reset here; y is 460 -> 464 then blocked
        for (int i = 0; i < 3; i++) begin
            tap(3);
        end
        push("bottom_clamp_edge", 4'b0101);
        check_next(32'(at_edge));

        if (val_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", val_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
